// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps at most one 32-bit fetch in flight
// and buffers responses in a 2-entry queue that feeds decode.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        if_fault
);

    typedef enum logic [1:0] {FETCH, FLUSH, HALT} state_t;

    state_t      state, state_nxt;
    logic [63:0] fetch_pc;
    logic [63:0] req_pc;
    logic        outstanding;
    logic [1:0]  count;
    logic        head;
    logic        tail;

    logic [63:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        q_fault [2];

    logic misaligned;
    logic req_fire;
    logic rsp_take;
    logic push;
    logic pop;

    always_comb begin
        state_nxt  = state;
        misaligned = (redirect_pc[1:0] != 2'b00);
        rsp_take   = imem_rsp_valid & outstanding;
        // Only one fetch in flight, and never more than the queue can absorb.
        imem_req_valid = rst_n & (state == FETCH) & ~outstanding
                       & (count != 2'd2) & ~redirect_valid;
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid & imem_req_ready;
        if_valid       = (count != 2'd0) & ~redirect_valid;
        pop            = if_valid & if_ready;
        push           = rsp_take & (state == FETCH) & ~redirect_valid;
        tail           = head ^ count[0];
        if_instr       = '0;
        if_pc          = '0;
        if_fault       = 1'b0;
        if (count != 2'd0) begin
            if_instr = q_instr[head];
            if_pc    = q_pc[head];
            if_fault = q_fault[head];
        end

        if (redirect_valid) begin
            if (misaligned)
                state_nxt = HALT;
            else if (rsp_take)
                state_nxt = FETCH;
            else if (outstanding | req_fire)
                state_nxt = FLUSH;
            else
                state_nxt = FETCH;
        end else if (rsp_take) begin
            case (state)
                FETCH:   state_nxt = imem_rsp_err ? HALT : FETCH;
                FLUSH:   state_nxt = FETCH;
                default: state_nxt = HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            count       <= 2'd0;
            head        <= 1'b0;
        end else if (redirect_valid) begin
            // A misaligned target leaves its fault entry behind; a stale fetch stays owed.
            fetch_pc <= redirect_pc;
            head     <= 1'b0;
            count    <= {1'b0, misaligned};
            if (rsp_take)
                outstanding <= 1'b0;
        end else begin
            if (req_fire) begin
                fetch_pc    <= fetch_pc + 64'd4;
                outstanding <= 1'b1;
            end else if (rsp_take) begin
                outstanding <= 1'b0;
            end
            if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;
            if (pop)
                head <= ~head;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            req_pc <= fetch_pc;
        if (redirect_valid && misaligned) begin
            q_pc[0]    <= redirect_pc;
            q_instr[0] <= NOP_INSTR;
            q_fault[0] <= 1'b1;
        end else if (push) begin
            q_pc[tail]    <= req_pc;
            q_instr[tail] <= imem_rsp_err ? NOP_INSTR : imem_rsp_data;
            q_fault[tail] <= imem_rsp_err;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a configurable-latency instruction memory
// that returns the low 32 address bits as the instruction word.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_fault;

    int          n_vec = 0;
    int          n_bad = 0;

    int          mem_lat = 1;
    int          mem_cnt;
    logic        mem_pend;
    logic [63:0] mem_addr;
    logic        err_en = 1'b0;
    logic [63:0] err_addr = 64'h10;

    logic [63:0] req_log [$];
    logic [63:0] pop_pc [$];
    logic [31:0] pop_instr [$];
    logic        pop_fault [$];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pend <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= '0;
        end else if (imem_req_valid && imem_req_ready) begin
            mem_pend <= 1'b1;
            mem_addr <= imem_req_addr;
            mem_cnt  <= mem_lat - 1;
        end else if (mem_pend) begin
            if (mem_cnt == 0) mem_pend <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end
    end

    assign imem_rsp_valid = mem_pend && (mem_cnt == 0);
    assign imem_rsp_data  = mem_addr[31:0];
    assign imem_rsp_err   = imem_rsp_valid && err_en && (mem_addr == err_addr);

    // Handshakes seen mid-cycle complete at the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_valid && if_ready) begin
                pop_pc.push_back(if_pc);
                pop_instr.push_back(if_instr);
                pop_fault.push_back(if_fault);
            end
            if (imem_req_valid && imem_req_ready)
                req_log.push_back(imem_req_addr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_instr.delete();
        pop_fault.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b1;
        imem_req_ready = 1'b1;
        err_en = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        clear_logs();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        n_vec++; if (if_instr !== 32'h0) begin n_bad++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
        n_vec++; if (if_pc !== 64'h0) begin n_bad++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        n_vec++; if (if_fault !== 1'b0) begin n_bad++; $display("FAIL rst_if_fault: got %b want 0", if_fault); end
        mem_lat = 1;
        do_reset();
        n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
        n_vec++; if (imem_req_addr !== 64'h0) begin n_bad++; $display("FAIL first_req_addr: got %h want 0", imem_req_addr); end
    endtask

    task automatic test_sequential();
        mem_lat = 1;
        do_reset();
        cyc(2);
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h0) begin n_bad++; $display("FAIL seq_first_entry: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
        n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4) begin n_bad++; $display("FAIL seq_second_req: got v=%b addr=%h want v=1 addr=4", imem_req_valid, imem_req_addr); end
        cyc(1);
        n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL seq_gap: got if_valid=%b want 0", if_valid); end
        cyc(9);
        n_vec++; if (pop_pc.size() != 5) begin n_bad++; $display("FAIL seq_pop_count: got %0d want 5", pop_pc.size()); end
        n_vec++; if (req_log.size() != 6) begin n_bad++; $display("FAIL seq_req_count: got %0d want 6", req_log.size()); end
        for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
            n_vec++; if (pop_pc[i] !== 64'(4 * i) || pop_instr[i] !== 32'(4 * i) || pop_fault[i] !== 1'b0) begin
                n_bad++; $display("FAIL seq_pop[%0d]: got pc=%h instr=%h f=%b want pc=%h instr=%h f=0", i, pop_pc[i], pop_instr[i], pop_fault[i], 4 * i, 4 * i);
            end
        end
        for (int i = 0; i < 6 && i < req_log.size(); i++) begin
            n_vec++; if (req_log[i] !== 64'(4 * i)) begin n_bad++; $display("FAIL seq_req[%0d]: got %h want %h", i, req_log[i], 4 * i); end
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        do_reset();
        if_ready = 1'b0;
        cyc(10);
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h0 || if_instr !== 32'h0) begin n_bad++; $display("FAIL bp_head: got v=%b pc=%h instr=%h want 1/0/0", if_valid, if_pc, if_instr); end
        n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_blocked: got %b want 0", imem_req_valid); end
        n_vec++; if (req_log.size() != 2) begin n_bad++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
        if_ready = 1'b1;
        cyc(1);
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h4 || if_instr !== 32'h4) begin n_bad++; $display("FAIL bp_second: got v=%b pc=%h instr=%h want 1/4/4", if_valid, if_pc, if_instr); end
        n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8) begin n_bad++; $display("FAIL bp_resume_req: got v=%b addr=%h want 1/8", imem_req_valid, imem_req_addr); end
        cyc(1);
        n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", if_valid); end
        n_vec++; if (pop_pc.size() != 2 || pop_pc[0] !== 64'h0 || pop_pc[1] !== 64'h4) begin n_bad++; $display("FAIL bp_pop_order: got n=%0d want 2 pops 0,4", pop_pc.size()); end
        cyc(1);
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h8 || if_instr !== 32'h8) begin n_bad++; $display("FAIL bp_third: got v=%b pc=%h instr=%h want 1/8/8", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_flush();
        mem_lat = 3;
        do_reset();
        if_ready = 1'b0;
        cyc(8);
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h0 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rd_full: got v=%b pc=%h req=%b want 1/0/0", if_valid, if_pc, imem_req_valid); end
        if_ready = 1'b1;
        cyc(1);
        if_ready = 1'b0;
        #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8 || if_pc !== 64'h4) begin n_bad++; $display("FAIL rd_req8: got req=%b addr=%h pc=%h want 1/8/4", imem_req_valid, imem_req_addr, if_pc); end
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h1000;
        clear_logs();
        #1;
        n_vec++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rd_gate: got if_valid=%b req=%b want 0/0", if_valid, imem_req_valid); end
        cyc(1);
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        #1;
        n_vec++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 64'h1000) begin n_bad++; $display("FAIL rd_flush: got if_valid=%b req=%b addr=%h want 0/0/1000", if_valid, imem_req_valid, imem_req_addr); end
        cyc(16);
        n_vec++; if (req_log.size() < 1 || req_log[0] !== 64'h1000) begin n_bad++; $display("FAIL rd_first_req: got n=%0d want first req 1000", req_log.size()); end
        n_vec++; if (pop_pc.size() < 2 || pop_pc[0] !== 64'h1000 || pop_instr[0] !== 32'h1000 || pop_fault[0] !== 1'b0 || pop_pc[1] !== 64'h1004) begin
            n_bad++; $display("FAIL rd_target_pops: got n=%0d want pops 1000,1004 first", pop_pc.size());
        end
    endtask

    task automatic test_misaligned();
        mem_lat = 1;
        do_reset();
        if_ready = 1'b0;
        cyc(2);
        redirect_valid = 1'b1;
        redirect_pc = 64'h2002;
        clear_logs();
        #1;
        n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mis_no_req: got %b want 0", imem_req_valid); end
        cyc(1);
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h2002 || if_instr !== 32'h13 || if_fault !== 1'b1) begin
            n_bad++; $display("FAIL mis_entry: got v=%b pc=%h instr=%h f=%b want 1/2002/13/1", if_valid, if_pc, if_instr, if_fault);
        end
        n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mis_halt_req: got %b want 0", imem_req_valid); end
        if_ready = 1'b1;
        cyc(6);
        n_vec++; if (pop_pc.size() != 1 || req_log.size() != 0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL mis_silence: got pops=%0d reqs=%0d v=%b want 1/0/0", pop_pc.size(), req_log.size(), if_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        cyc(1);
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000) begin n_bad++; $display("FAIL mis_resume_req: got v=%b addr=%h want 1/3000", imem_req_valid, imem_req_addr); end
        cyc(4);
        n_vec++; if (pop_pc.size() != 2 || pop_pc[1] !== 64'h3000 || pop_instr[1] !== 32'h3000 || pop_fault[1] !== 1'b0) begin n_bad++; $display("FAIL mis_resume_pop: got n=%0d want second pop 3000", pop_pc.size()); end

        // Misaligned target while a fetch is still in flight.
        mem_lat = 3;
        do_reset();
        if_ready = 1'b0;
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h2006;
        cyc(1);
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h2006 || if_fault !== 1'b1) begin n_bad++; $display("FAIL mis_stale_entry: got v=%b pc=%h f=%b want 1/2006/1", if_valid, if_pc, if_fault); end
        cyc(4);
        clear_logs();
        if_ready = 1'b1;
        cyc(3);
        n_vec++; if (pop_pc.size() != 1 || pop_pc[0] !== 64'h2006) begin n_bad++; $display("FAIL mis_stale_drop: got pops=%0d want 1 pop of 2006", pop_pc.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        cyc(1);
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000) begin n_bad++; $display("FAIL mis_stale_resume: got v=%b addr=%h want 1/3000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_fetch_error();
        mem_lat = 1;
        do_reset();
        err_en = 1'b1;
        err_addr = 64'h10;
        cyc(14);
        n_vec++; if (req_log.size() != 5 || req_log[4] !== 64'h10) begin n_bad++; $display("FAIL err_req_stop: got reqs=%0d want 5 ending at 10", req_log.size()); end
        n_vec++; if (pop_pc.size() != 5) begin n_bad++; $display("FAIL err_pop_count: got %0d want 5", pop_pc.size()); end
        n_vec++; if (pop_pc.size() == 5 && (pop_pc[4] !== 64'h10 || pop_instr[4] !== 32'h13 || pop_fault[4] !== 1'b1)) begin
            n_bad++; $display("FAIL err_entry: got pc=%h instr=%h f=%b want 10/13/1", pop_pc[4], pop_instr[4], pop_fault[4]);
        end
        n_vec++; if (pop_pc.size() == 5 && (pop_instr[3] !== 32'hc || pop_fault[3] !== 1'b0)) begin n_bad++; $display("FAIL err_prev_entry: got instr=%h f=%b want c/0", pop_instr[3], pop_fault[3]); end
        n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL err_halt: got req=%b want 0", imem_req_valid); end
        err_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        cyc(1);
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h40) begin n_bad++; $display("FAIL err_resume: got v=%b addr=%h want 1/40", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stall_reset();
        mem_lat = 1;
        do_reset();
        cyc(4);
        if_ready = 1'b0;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8) begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%b addr=%h want 1/8", i, imem_req_valid, imem_req_addr); end
            cyc(1);
        end
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 64'h4) begin n_bad++; $display("FAIL stall_queue: got v=%b pc=%h want 1/4", if_valid, if_pc); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got req=%b if=%b want 0/0", imem_req_valid, if_valid); end
        n_vec++; if (if_pc !== 64'h0 || if_instr !== 32'h0 || if_fault !== 1'b0) begin n_bad++; $display("FAIL async_rst_data: got pc=%h instr=%h f=%b want 0/0/0", if_pc, if_instr, if_fault); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        #1;
        n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin n_bad++; $display("FAIL rst_restart: got v=%b addr=%h want 1/0", imem_req_valid, imem_req_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_flush();
        test_misaligned();
        test_fetch_error();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
